// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared types and helpers for the RSA host byte links
// Purpose : state encoding, byte width and index-width helper shared by the
//           result transmitter and the operand loader.
// Ports   : none (package).
package rsa_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESENT  = 2'd1,
    WAIT_LOW = 2'd2,
    DONE     = 2'd3
  } tx_state_e;

  // Width of a byte index over n_bytes bytes; never narrower than one bit.
  function automatic int idx_width(input int n_bytes);
    return (n_bytes <= 1) ? 1 : $clog2(n_bytes);
  endfunction

endpackage

// File: rtl/rsa_result_tx_if.sv
// rtl/rsa_result_tx_if.sv - core/host side signal bundle of the result transmitter
// Purpose : groups the start/result capture and the valid/ack byte handshake.
// Signals : start_i, result_i[WIDTH], ack_i   (towards the transmitter)
//           data_o[8], valid_o, busy_o, done_o, err_o (from the transmitter)
// Modports: master = core + host side, slave = transmitter.
interface rsa_result_tx_if
  import rsa_pkg::*;
#(
  parameter int WIDTH = 32
) ();

  logic              start_i;
  logic [WIDTH-1:0]  result_i;
  logic              ack_i;
  logic [BYTE_W-1:0] data_o;
  logic              valid_o;
  logic              busy_o;
  logic              done_o;
  logic              err_o;

  modport master (
    output start_i, result_i, ack_i,
    input  data_o, valid_o, busy_o, done_o, err_o
  );

  modport slave (
    input  start_i, result_i, ack_i,
    output data_o, valid_o, busy_o, done_o, err_o
  );

endinterface

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for a single asynchronous pin
// Purpose : brings an asynchronous level into the clk domain, 2 cycles latency.
// Ports   : clk, rst (sync, active-high, clears both flops to 0),
//           d_i (async input), q_o (synchronised output).
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/rsa_result_tx.sv
// rtl/rsa_result_tx.sv - byte-serial transmitter of the RSA result word
// Purpose : captures a WIDTH-bit result on start and hands it to the host one
//           byte at a time, LSB first, under a four-phase valid/ack handshake.
// Ports   : clk, rst (sync, active-high)
//           bus (slave): start_i, result_i, ack_i in; data_o, valid_o,
//           busy_o, done_o, err_o out.
// Params  : WIDTH (multiple of 8, >= 8), TIMEOUT (cycles per phase, 0 = off).
module rsa_result_tx
  import rsa_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 0
) (
  input logic             clk,
  input logic             rst,
  rsa_result_tx_if.slave  bus
);

  localparam int BYTES = WIDTH / BYTE_W;
  localparam int IW    = idx_width(BYTES);
  localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [IW-1:0] LAST_IDX = IW'(BYTES - 1);
  // Timer value on the last allowed cycle of a phase; the abort happens on
  // the edge that would take the count to TIMEOUT.
  localparam logic [TW-1:0] TMAX     = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic ack_s;

  sync_2ff u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.ack_i),
    .q_o (ack_s)
  );

  tx_state_e         state_q, state_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [WIDTH-1:0]  shift_nx;
  logic [IW-1:0]     idx_q, idx_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [BYTE_W-1:0] data_q, data_d;
  logic              err_q, err_d;
  logic              timed_out;
  logic [TW-1:0]     timer_inc;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    idx_d     = idx_q;
    data_d    = data_q;
    err_d     = err_q;
    timer_d   = '0;
    shift_nx  = shift_q >> BYTE_W;
    timed_out = (TIMEOUT > 0) && (timer_q == TMAX);
    // With the timeout disabled the timer is parked at zero.
    timer_inc = (TIMEOUT > 0) ? timer_q + 1'b1 : '0;

    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          shift_d = bus.result_i;
          idx_d   = '0;
          err_d   = 1'b0;
          data_d  = bus.result_i[BYTE_W-1:0];
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (ack_s) begin
          state_d = WAIT_LOW;
        end else if (timed_out) begin
          err_d   = 1'b1;
          data_d  = '0;
          state_d = IDLE;
        end else begin
          timer_d = timer_inc;
        end
      end
      WAIT_LOW: begin
        if (!ack_s) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            // Next byte and valid rise together on the same edge.
            shift_d = shift_nx;
            idx_d   = idx_q + 1'b1;
            data_d  = shift_nx[BYTE_W-1:0];
            state_d = PRESENT;
          end
        end else if (timed_out) begin
          err_d   = 1'b1;
          data_d  = '0;
          state_d = IDLE;
        end else begin
          timer_d = timer_inc;
        end
      end
      DONE: begin
        data_d  = '0;
        state_d = IDLE;
      end
      default: begin
        data_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      timer_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign bus.data_o  = data_q;
  assign bus.valid_o = (state_q == PRESENT);
  assign bus.busy_o  = (state_q != IDLE);
  assign bus.done_o  = (state_q == DONE);
  assign bus.err_o   = err_q;

endmodule
